// File: rtl/forward_unit_if.sv
// forward_unit_if: pipeline-side bundle of hazard inputs and forwarding/stall/counter outputs
interface forward_unit_if #(parameter int CNT_W = 16);
  logic [4:0] i_id_rs1, i_id_rs2;
  logic i_id_use_rs1, i_id_use_rs2;
  logic [4:0] i_ex_rs1, i_ex_rs2;
  logic [31:0] i_ex_rs1_data, i_ex_rs2_data;
  logic [4:0] i_ex_rd;
  logic i_ex_mem_read;
  logic [4:0] i_mem_rd;
  logic i_mem_reg_write;
  logic [31:0] i_mem_result;
  logic [4:0] i_wb_rd;
  logic i_wb_reg_write;
  logic [31:0] i_wb_result;
  logic [1:0] o_fwd_a, o_fwd_b;
  logic [31:0] o_op_a, o_op_b;
  logic o_stall;
  logic [CNT_W-1:0] o_fwd_count, o_stall_count;
  modport master (
    output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_rs1, i_ex_rs2,
           i_ex_rs1_data, i_ex_rs2_data, i_ex_rd, i_ex_mem_read, i_mem_rd,
           i_mem_reg_write, i_mem_result, i_wb_rd, i_wb_reg_write, i_wb_result,
    input  o_fwd_a, o_fwd_b, o_op_a, o_op_b, o_stall, o_fwd_count, o_stall_count
  );
  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2, i_ex_rs1, i_ex_rs2,
           i_ex_rs1_data, i_ex_rs2_data, i_ex_rd, i_ex_mem_read, i_mem_rd,
           i_mem_reg_write, i_mem_result, i_wb_rd, i_wb_reg_write, i_wb_result,
    output o_fwd_a, o_fwd_b, o_op_a, o_op_b, o_stall, o_fwd_count, o_stall_count
  );
endinterface

// File: rtl/forward_unit.sv
// forward_unit: EX-stage operand forwarding, load-use stall detection and saturating event counters
module forward_unit #(parameter int CNT_W = 16) (
  input logic i_clk,
  input logic i_rst,
  forward_unit_if.slave bus
);
  logic mem_a, mem_b, wb_a, wb_b, fwd_any;
  logic [CNT_W-1:0] fwd_count, stall_count;
  // rd != 0 also keeps x0 from ever matching, since a matching source would have to be x0 too
  always_comb begin
    mem_a = bus.i_mem_reg_write && bus.i_mem_rd != 5'd0 && bus.i_mem_rd == bus.i_ex_rs1;
    mem_b = bus.i_mem_reg_write && bus.i_mem_rd != 5'd0 && bus.i_mem_rd == bus.i_ex_rs2;
    wb_a = bus.i_wb_reg_write && bus.i_wb_rd != 5'd0 && bus.i_wb_rd == bus.i_ex_rs1;
    wb_b = bus.i_wb_reg_write && bus.i_wb_rd != 5'd0 && bus.i_wb_rd == bus.i_ex_rs2;
    bus.o_fwd_a = mem_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
    bus.o_fwd_b = mem_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
    bus.o_op_a = mem_a ? bus.i_mem_result : wb_a ? bus.i_wb_result : bus.i_ex_rs1_data;
    bus.o_op_b = mem_b ? bus.i_mem_result : wb_b ? bus.i_wb_result : bus.i_ex_rs2_data;
    bus.o_stall = bus.i_ex_mem_read && bus.i_ex_rd != 5'd0 &&
                  ((bus.i_id_use_rs1 && bus.i_id_rs1 == bus.i_ex_rd) ||
                   (bus.i_id_use_rs2 && bus.i_id_rs2 == bus.i_ex_rd));
    fwd_any = mem_a | mem_b | wb_a | wb_b;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fwd_count <= '0;
      stall_count <= '0;
    end else begin
      if (fwd_any && fwd_count != '1) fwd_count <= fwd_count + CNT_W'(1);
      if (bus.o_stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end
  assign bus.o_fwd_count = fwd_count;
  assign bus.o_stall_count = stall_count;
endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit: random and directed checks of two forward_unit instances (CNT_W 16 and 2) against a reference model
module tb_forward_unit;
  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic use1, use2;
    logic [4:0] ex_rs1, ex_rs2;
    logic [31:0] d1, d2;
    logic [4:0] ex_rd;
    logic ex_mr;
    logic [4:0] mem_rd;
    logic mem_we;
    logic [31:0] mem_res;
    logic [4:0] wb_rd;
    logic wb_we;
    logic [31:0] wb_res;
  } stim_t;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  longint fc16 = 0, sc16 = 0, fc2 = 0, sc2 = 0;
  forward_unit_if #(16) b16();
  forward_unit_if #(2) b2();
  forward_unit #(.CNT_W(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(b16));
  forward_unit #(.CNT_W(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic stim_t idle();
    stim_t s;
    s.id_rs1 = 0; s.id_rs2 = 0; s.use1 = 0; s.use2 = 0;
    s.ex_rs1 = 0; s.ex_rs2 = 0; s.d1 = 32'h0101_0101; s.d2 = 32'h0202_0202;
    s.ex_rd = 0; s.ex_mr = 0; s.mem_rd = 0; s.mem_we = 0; s.mem_res = 32'hCAFE_0001;
    s.wb_rd = 0; s.wb_we = 0; s.wb_res = 32'hCAFE_0002;
    return s;
  endfunction
  function automatic stim_t rnd();
    stim_t s;
    s.id_rs1 = 5'($urandom_range(0, 7)); s.id_rs2 = 5'($urandom_range(0, 7));
    s.use1 = 1'($urandom); s.use2 = 1'($urandom);
    s.ex_rs1 = 5'($urandom_range(0, 7)); s.ex_rs2 = 5'($urandom_range(0, 7));
    s.d1 = $urandom; s.d2 = $urandom;
    s.ex_rd = 5'($urandom_range(0, 7)); s.ex_mr = 1'($urandom);
    s.mem_rd = 5'($urandom_range(0, 7)); s.mem_we = 1'($urandom);
    s.mem_res = $urandom;
    s.wb_rd = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    s.wb_we = 1'($urandom); s.wb_res = $urandom;
    return s;
  endfunction
  task automatic apply(stim_t s);
    b16.i_id_rs1 = s.id_rs1; b2.i_id_rs1 = s.id_rs1;
    b16.i_id_rs2 = s.id_rs2; b2.i_id_rs2 = s.id_rs2;
    b16.i_id_use_rs1 = s.use1; b2.i_id_use_rs1 = s.use1;
    b16.i_id_use_rs2 = s.use2; b2.i_id_use_rs2 = s.use2;
    b16.i_ex_rs1 = s.ex_rs1; b2.i_ex_rs1 = s.ex_rs1;
    b16.i_ex_rs2 = s.ex_rs2; b2.i_ex_rs2 = s.ex_rs2;
    b16.i_ex_rs1_data = s.d1; b2.i_ex_rs1_data = s.d1;
    b16.i_ex_rs2_data = s.d2; b2.i_ex_rs2_data = s.d2;
    b16.i_ex_rd = s.ex_rd; b2.i_ex_rd = s.ex_rd;
    b16.i_ex_mem_read = s.ex_mr; b2.i_ex_mem_read = s.ex_mr;
    b16.i_mem_rd = s.mem_rd; b2.i_mem_rd = s.mem_rd;
    b16.i_mem_reg_write = s.mem_we; b2.i_mem_reg_write = s.mem_we;
    b16.i_mem_result = s.mem_res; b2.i_mem_result = s.mem_res;
    b16.i_wb_rd = s.wb_rd; b2.i_wb_rd = s.wb_rd;
    b16.i_wb_reg_write = s.wb_we; b2.i_wb_reg_write = s.wb_we;
    b16.i_wb_result = s.wb_res; b2.i_wb_result = s.wb_res;
  endtask
  // Which stage supplies a source: the youngest writer of a nonzero register, else the register file.
  function automatic logic [1:0] src_of(logic [4:0] rs, stim_t s);
    if (rs == 0) return 2'b00;
    if (s.mem_we && s.mem_rd == rs) return 2'b10;
    if (s.wb_we && s.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [31:0] val_of(logic [1:0] src, logic [31:0] rf, stim_t s);
    return (src == 2'b10) ? s.mem_res : (src == 2'b01) ? s.wb_res : rf;
  endfunction
  function automatic logic needs_stall(stim_t s);
    if (!s.ex_mr || s.ex_rd == 0) return 0;
    return (s.use1 && s.id_rs1 == s.ex_rd) || (s.use2 && s.id_rs2 == s.ex_rd);
  endfunction
  function automatic longint bump(longint c, logic ev, logic r, longint max);
    if (r) return 0;
    return (ev && c < max) ? c + 1 : c;
  endfunction
  task automatic step(stim_t s, logic r);
    logic [1:0] fa, fb;
    logic st;
    @(negedge clk);
    apply(s);
    rst = r;
    #1;
    fa = src_of(s.ex_rs1, s);
    fb = src_of(s.ex_rs2, s);
    st = needs_stall(s);
    chk("fwd_a", b16.o_fwd_a, fa);
    chk("fwd_b", b16.o_fwd_b, fb);
    chk("op_a", b16.o_op_a, val_of(fa, s.d1, s));
    chk("op_b", b16.o_op_b, val_of(fb, s.d2, s));
    chk("stall", b16.o_stall, st);
    chk("stall_w2", b2.o_stall, st);
    fc16 = bump(fc16, fa != 0 || fb != 0, r, 65535);
    sc16 = bump(sc16, st, r, 65535);
    fc2 = bump(fc2, fa != 0 || fb != 0, r, 3);
    sc2 = bump(sc2, st, r, 3);
    @(posedge clk);
    #1;
    chk("fwd_count", b16.o_fwd_count, fc16);
    chk("stall_count", b16.o_stall_count, sc16);
    chk("fwd_count_w2", b2.o_fwd_count, fc2);
    chk("stall_count_w2", b2.o_stall_count, sc2);
  endtask
  initial begin
    stim_t s;
    s = idle();
    step(s, 1);
    step(s, 1);
    chk("rst_fwd_count", b16.o_fwd_count, 0);
    chk("rst_stall_count", b16.o_stall_count, 0);
    s = idle();
    s.ex_rs1 = 5; s.mem_rd = 5; s.mem_we = 1; s.mem_res = 32'hAAAA_0000;
    s.wb_rd = 5; s.wb_we = 1; s.wb_res = 32'h1111_1111;
    step(s, 0);
    chk("mem_wins_sel", b16.o_fwd_a, 2'b10);
    chk("mem_wins_op", b16.o_op_a, 32'hAAAA_0000);
    chk("fwd_cnt_1", b16.o_fwd_count, 1);
    step(s, 0);
    chk("fwd_cnt_2", b16.o_fwd_count, 2);
    s = idle();
    s.ex_rs2 = 7; s.wb_rd = 7; s.wb_we = 1; s.wb_res = 32'h1234_5678; s.d2 = 32'hDEAD_BEEF;
    s.ex_rs1 = 7;
    step(s, 0);
    chk("wb_sel", b16.o_fwd_b, 2'b01);
    chk("wb_op", b16.o_op_b, 32'h1234_5678);
    chk("fwd_cnt_3_once", b16.o_fwd_count, 3);
    step(s, 1);
    chk("rst_mid_fwd_count", b16.o_fwd_count, 0);
    s = idle();
    s.ex_rs1 = 0; s.mem_rd = 0; s.mem_we = 1; s.wb_rd = 0; s.wb_we = 1; s.d1 = 32'h5555_AAAA;
    step(s, 0);
    chk("x0_sel", b16.o_fwd_a, 2'b00);
    chk("x0_op", b16.o_op_a, 32'h5555_AAAA);
    s = idle();
    s.ex_mr = 1; s.ex_rd = 3; s.id_rs2 = 3; s.use2 = 1;
    step(s, 1);
    chk("rst_stall_cnt", b16.o_stall_count, 0);
    step(s, 0);
    chk("stall_cnt_1", b16.o_stall_count, 1);
    for (int i = 0; i < 4; i++) step(s, 0);
    chk("stall_sat_w2", b2.o_stall_count, 3);
    s.use2 = 0;
    step(s, 0);
    chk("no_use_stall", b16.o_stall, 0);
    s = idle();
    s.ex_mr = 1; s.ex_rd = 0; s.id_rs1 = 0; s.use1 = 1;
    step(s, 0);
    chk("x0_load_no_stall", b16.o_stall, 0);
    for (int i = 0; i < 400; i++) step(rnd(), 1'($urandom_range(0, 24) == 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/forward_unit.md
FORWARD_UNIT -- requirements
Module: forward_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of the two event counters.
REQ-002 i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 i_rst  in  1  reset, synchronous and active-high.
REQ-004 i_id_rs1, i_id_rs2  in  5 each  source register addresses of the decode-stage instruction.
REQ-005 i_id_use_rs1, i_id_use_rs2  in  1 each  decode-stage instruction actually reads rs1/rs2.
REQ-006 i_ex_rs1, i_ex_rs2  in  5 each  source register addresses of the execute-stage instruction.
REQ-007 i_ex_rs1_data, i_ex_rs2_data  in  32 each  register-file values for the execute-stage instruction.
REQ-008 i_ex_rd  in  5, and i_ex_mem_read  in  1: execute-stage destination register and its is-load flag.
REQ-009 i_mem_rd  in  5, i_mem_reg_write  in  1, i_mem_result  in  32: memory-stage writeback target, enable and ALU result.
REQ-010 i_wb_rd  in  5, i_wb_reg_write  in  1, i_wb_result  in  32: writeback-stage target, enable and final result.
REQ-011 o_fwd_a, o_fwd_b  out  2 each  operand source select: 00 register file, 10 memory stage, 01 writeback stage.
REQ-012 o_op_a, o_op_b  out  32 each  forwarded execute operands.
REQ-013 o_stall  out  1  load-use hazard; freeze PC and IF/ID and bubble ID/EX this cycle.
REQ-014 o_fwd_count, o_stall_count  out  CNT_W each  saturating event counters.

Function
REQ-015 o_fwd_a SHALL be 10 when i_mem_reg_write=1, i_mem_rd!=0 and i_mem_rd==i_ex_rs1.
REQ-016 Otherwise o_fwd_a SHALL be 01 when i_wb_reg_write=1, i_wb_rd!=0 and i_wb_rd==i_ex_rs1.
REQ-017 Otherwise o_fwd_a SHALL be 00; o_fwd_b SHALL follow REQ-015..017 using i_ex_rs2.
REQ-018 When both the memory and writeback stages match, the memory stage SHALL win (it holds the younger value).
REQ-019 Register x0 SHALL never be forwarded; a source of x0 SHALL always select 00.
REQ-020 o_op_a/o_op_b SHALL be i_mem_result, i_wb_result or i_ex_rsN_data per select, combinationally and with zero latency.
REQ-021 o_stall SHALL be 1 combinationally when i_ex_mem_read=1, i_ex_rd!=0 and (i_id_use_rs1 and i_id_rs1==i_ex_rd, or i_id_use_rs2 and i_id_rs2==i_ex_rd).
REQ-022 In all other cases, o_stall SHALL be 0.
REQ-023 Forwarding and stall outputs SHALL be purely combinational and SHALL NOT depend on reset or counter state.
REQ-024 On each rising edge with i_rst=0, o_fwd_count SHALL increment by 1 if o_fwd_a!=00 or o_fwd_b!=00.
REQ-025 The increment in REQ-024 SHALL be at most 1 per cycle, even if both operands forward.
REQ-026 On each rising edge with i_rst=0, o_stall_count SHALL increment by 1 if o_stall=1.
REQ-027 Both counters SHALL saturate at 2^CNT_W-1 and hold there without wrapping.
REQ-028 Counter outputs SHALL be driven directly from registers (one-cycle latency after the event).

Reset
REQ-029 On a rising edge with i_rst=1, both counters SHALL become 0.
REQ-030 While i_rst=1, combinational outputs SHALL still reflect the current inputs.
REQ-031 Asserting i_rst mid-operation SHALL clear the counters on the next edge and discard any concurrent event that cycle.

Verification
REQ-032 i_ex_rs1=5, mem rd=5 we=1 result=0xAAAA0000, wb rd=5 we=1 result=0x11111111 -> o_fwd_a=10, o_op_a=0xAAAA0000.
REQ-033 i_ex_rs2=7, mem we=0, wb rd=7 we=1 result=0x12345678, rs2_data=0xDEADBEEF -> o_fwd_b=01, o_op_b=0x12345678.
REQ-034 i_ex_rs1=0, mem rd=0 we=1 -> o_fwd_a=00, o_op_a=i_ex_rs1_data.
REQ-035 ex mem_read=1 rd=3, id rs2=3 use_rs2=1 -> o_stall=1 and o_stall_count 0->1 after one edge; with use_rs2=0 -> o_stall=0.
REQ-036 Reset 2 cycles, then a forwarding condition held for 3 edges -> o_fwd_count=0,1,2,3.
REQ-037 Then i_rst=1 for one edge -> o_fwd_count=0.
REQ-038 CNT_W=2 with a stall held for 5 edges -> o_stall_count ends at 3 (saturated).
